// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache for the fetch stage.
//   clk, rst          : clock and synchronous active-high reset
//   reqValid, reqAdr  : fetch request and byte address (bits [1:0] ignored)
//   reqReady          : request accepted when high together with reqValid
//   respValid         : one-cycle pulse; respInstr carries the fetched word
//   respInstr         : fetched instruction, held until the next response
//   flush             : invalidate all lines
//   memReq, memAdr    : word-serial line-fill request and word address
//   memAck, memData   : fill acknowledge and data for the current request
// Hits answer one cycle after acceptance. Misses fill the whole line from
// word 0 upward, then answer with the requested word.
module instr_cache #(
  parameter int WORD_LENGTH    = 32,
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reqValid,
  input  logic [WORD_LENGTH-1:0] reqAdr,
  output logic                   reqReady,
  output logic                   respValid,
  output logic [WORD_LENGTH-1:0] respInstr,
  input  logic                   flush,
  output logic                   memReq,
  output logic [WORD_LENGTH-1:0] memAdr,
  input  logic                   memAck,
  input  logic [WORD_LENGTH-1:0] memData
);

  localparam int OFF_W   = $clog2(WORDS_PER_LINE);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_W   = WORD_LENGTH - IDX_W - OFF_W - 2;
  localparam int LSB_IDX = 2 + OFF_W;
  localparam int LSB_TAG = 2 + OFF_W + IDX_W;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [LINES-1:0]       valid_q, valid_d;
  logic                   pend_q, pend_d;
  logic [WORD_LENGTH-1:2] adr_q, adr_d;
  logic [OFF_W-1:0]       cnt_q, cnt_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [WORD_LENGTH-1:0] resp_instr_q, resp_instr_d;
  logic                   mem_req_q, mem_req_d;
  logic [WORD_LENGTH-1:0] mem_adr_q, mem_adr_d;

  // Storage without reset; only the valid bits qualify it.
  logic [WORD_LENGTH-1:0] data_mem [LINES*WORDS_PER_LINE];
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic                   data_we;
  logic                   tag_we;

  logic [OFF_W-1:0] req_off, fill_off;
  logic [IDX_W-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0] req_tag, fill_tag;
  logic             hit;
  logic             accept;
  logic             last_word;
  logic             unused_adr_lsbs;

  always_comb begin
    req_off         = reqAdr[LSB_IDX-1:2];
    req_idx         = reqAdr[LSB_TAG-1:LSB_IDX];
    req_tag         = reqAdr[WORD_LENGTH-1:LSB_TAG];
    fill_off        = adr_q[LSB_IDX-1:2];
    fill_idx        = adr_q[LSB_TAG-1:LSB_IDX];
    fill_tag        = adr_q[WORD_LENGTH-1:LSB_TAG];
    unused_adr_lsbs = ^reqAdr[1:0];
  end

  always_comb begin
    reqReady  = (state_q == IDLE) && !flush && !rst;
    accept    = reqValid && reqReady;
    hit       = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
    last_word = (cnt_q == '1);
  end

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    pend_d       = pend_q;
    adr_d        = adr_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_instr_d = resp_instr_q;
    mem_req_d    = mem_req_q;
    mem_adr_d    = mem_adr_q;
    data_we      = 1'b0;
    tag_we       = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          state_d = FLUSH;
        end else if (accept) begin
          if (hit) begin
            resp_valid_d = 1'b1;
            resp_instr_d = data_mem[{req_idx, req_off}];
          end else begin
            adr_d     = reqAdr[WORD_LENGTH-1:2];
            cnt_d     = '0;
            mem_req_d = 1'b1;
            mem_adr_d = {req_tag, req_idx, {OFF_W{1'b0}}, 2'b00};
            state_d   = FILL;
          end
        end
      end

      FILL: begin
        if (flush) begin
          pend_d = 1'b1;
        end
        if (memAck && mem_req_q) begin
          data_we = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (last_word) begin
            valid_d[fill_idx] = 1'b1;
            tag_we            = 1'b1;
            mem_req_d         = 1'b0;
            resp_valid_d      = 1'b1;
            // The requested word may be the one arriving right now.
            resp_instr_d      = (fill_off == cnt_q) ? memData
                                                    : data_mem[{fill_idx, fill_off}];
            state_d           = (pend_q || flush) ? FLUSH : IDLE;
          end else begin
            mem_adr_d = {fill_tag, fill_idx, cnt_q + 1'b1, 2'b00};
          end
        end
      end

      FLUSH: begin
        valid_d = '0;
        pend_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      pend_q       <= 1'b0;
      adr_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_instr_q <= '0;
      mem_req_q    <= 1'b0;
      mem_adr_q    <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      pend_q       <= pend_d;
      adr_q        <= adr_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_instr_q <= resp_instr_d;
      mem_req_q    <= mem_req_d;
      mem_adr_q    <= mem_adr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (data_we) begin
      data_mem[{fill_idx, cnt_q}] <= memData;
    end
    if (tag_we) begin
      tag_mem[fill_idx] <= fill_tag;
    end
  end

  always_comb begin
    respValid = resp_valid_q;
    respInstr = resp_instr_q;
    memReq    = mem_req_q;
    memAdr    = mem_adr_q;
  end

endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed stimulus for instr_cache with a line-level
// reference model checked every cycle, plus literal expectations for the
// cold miss, hit stream, conflict, flush-during-fill, reset-mid-fill and
// flush-versus-request scenarios. Memory returns data equal to the address.
module tb_instr_cache;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic [31:0] reqAdr;
  logic        reqReady;
  logic        respValid;
  logic [31:0] respInstr;
  logic        flush;
  logic        memReq;
  logic [31:0] memAdr;
  logic        memAck;
  logic [31:0] memData;

  always #5 clk = ~clk;

  instr_cache #(
    .WORD_LENGTH    (32),
    .LINES          (16),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqAdr    (reqAdr),
    .reqReady  (reqReady),
    .respValid (respValid),
    .respInstr (respInstr),
    .flush     (flush),
    .memReq    (memReq),
    .memAdr    (memAdr),
    .memAck    (memAck),
    .memData   (memData)
  );

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned cyc        = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: per-line valid/tag/words, remaining fill words as a
  // queue of addresses, and the next-cycle expected response.
  bit          m_live = 1'b0;
  bit          m_valid [16];
  logic [23:0] m_tag   [16];
  logic [31:0] m_data  [16][4];
  logic [31:0] fill_q[$];
  logic [31:0] fill_req;
  bit          pend = 1'b0;
  bit          flush_cycle = 1'b0;
  bit          exp_rv = 1'b0;
  logic [31:0] exp_ri = '0;
  bit          exp_adr_zero = 1'b0;

  logic [31:0] resp_log[$];
  int unsigned resp_cyc_log[$];
  logic [31:0] ack_adr_log[$];
  int unsigned ack_total  = 0;
  int unsigned accept_cyc = 0;

  always @(negedge clk) begin : model
    logic [31:0] a;
    int unsigned ix;
    bit          exp_ready;

    if (m_live) begin
      exp_ready = (fill_q.size() == 0) && !flush_cycle && !flush && !rst;
      chk("reqReady", {31'b0, reqReady}, {31'b0, exp_ready});
      chk("respValid", {31'b0, respValid}, {31'b0, exp_rv});
      chk("respInstr", respInstr, exp_ri);
      chk("memReq", {31'b0, memReq}, {31'b0, fill_q.size() != 0});
      if (fill_q.size() != 0) chk("memAdr", memAdr, fill_q[0]);
      else if (exp_adr_zero) chk("memAdr_reset", memAdr, 32'h0);

      if (respValid === 1'b1) begin
        resp_log.push_back(respInstr);
        resp_cyc_log.push_back(cyc);
      end
      if (reqValid && reqReady) accept_cyc = cyc;
      if (memAck && memReq) begin
        ack_total++;
        ack_adr_log.push_back(memAdr);
      end
    end

    if (rst) begin
      m_live = 1'b1;
      foreach (m_valid[i]) m_valid[i] = 1'b0;
      fill_q.delete();
      pend = 1'b0;
      flush_cycle = 1'b0;
      exp_rv = 1'b0;
      exp_ri = '0;
      exp_adr_zero = 1'b1;
    end else if (m_live) begin
      exp_rv = 1'b0;
      if (flush_cycle) begin
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        flush_cycle = 1'b0;
        pend = 1'b0;
      end else if (fill_q.size() != 0) begin
        if (flush) pend = 1'b1;
        if (memAck) begin
          a = fill_q.pop_front();
          m_data[(a >> 4) & 15][(a >> 2) & 3] = a;
          if (fill_q.size() == 0) begin
            ix = (fill_req >> 4) & 15;
            m_valid[ix] = 1'b1;
            m_tag[ix] = fill_req[31:8];
            exp_rv = 1'b1;
            exp_ri = m_data[ix][(fill_req >> 2) & 3];
            if (pend) flush_cycle = 1'b1;
          end
        end
      end else if (flush) begin
        flush_cycle = 1'b1;
      end else if (reqValid) begin
        ix = (reqAdr >> 4) & 15;
        if (m_valid[ix] && m_tag[ix] == reqAdr[31:8]) begin
          exp_rv = 1'b1;
          exp_ri = m_data[ix][(reqAdr >> 2) & 3];
        end else begin
          for (int i = 0; i < 4; i++) fill_q.push_back({reqAdr[31:4], 4'b0} + 32'(4 * i));
          fill_req = reqAdr;
          exp_adr_zero = 1'b0;
        end
      end
    end
  end

  // Memory responder: data = address, configurable gap between acks,
  // optional stray acks while no request is outstanding.
  int unsigned ack_gap  = 0;
  bit          spurious = 1'b0;

  initial begin : responder
    int unsigned gap;
    gap = 0;
    memAck = 1'b0;
    memData = '0;
    forever begin
      @(posedge clk);
      #1;
      if (memReq === 1'b1) begin
        if (gap == 0) begin
          memAck = 1'b1;
          memData = memAdr;
          gap = ack_gap;
        end else begin
          memAck = 1'b0;
          gap--;
        end
      end else begin
        gap = 0;
        memAck = spurious;
        memData = 32'hDEAD_BEEF;
      end
    end
  end

  task automatic issue(input logic [31:0] adr);
    bit got;
    got = 1'b0;
    reqValid = 1'b1;
    reqAdr = adr;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (reqReady === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: addr %h reqReady %b, required 1", adr, reqReady);
    end
  endtask

  task automatic wait_quiet();
    bit quiet;
    quiet = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #3;
      if (fill_q.size() == 0 && !flush_cycle) begin
        quiet = 1'b1;
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    if (!quiet) begin
      vectors++;
      miscompares++;
      $display("FAIL quiet_timeout: fill words left %0d, required 0", fill_q.size());
    end
  endtask

  initial begin : stim
    int unsigned n0, r0, a0, ac, fc;
    bit          done;

    rst = 1'b1;
    reqValid = 1'b0;
    reqAdr = '0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Cold miss
    n0 = ack_adr_log.size();
    r0 = resp_log.size();
    issue(32'h0000_1004);
    ac = accept_cyc;
    wait_quiet();
    chk("cold_ack_count", 32'(ack_adr_log.size() - n0), 32'd4);
    chk("cold_adr0", ack_adr_log[n0], 32'h1000);
    chk("cold_adr1", ack_adr_log[n0 + 1], 32'h1004);
    chk("cold_adr2", ack_adr_log[n0 + 2], 32'h1008);
    chk("cold_adr3", ack_adr_log[n0 + 3], 32'h100C);
    chk("cold_resp", resp_log[r0], 32'h0000_1004);
    chk("cold_latency", 32'(resp_cyc_log[r0] - ac), 32'd5);

    // Hit stream, with stray acks while idle
    spurious = 1'b1;
    a0 = ack_total;
    r0 = resp_log.size();
    issue(32'h1000);
    issue(32'h1008);
    issue(32'h100C);
    wait_quiet();
    spurious = 1'b0;
    chk("hit_resp0", resp_log[r0], 32'h1000);
    chk("hit_resp1", resp_log[r0 + 1], 32'h1008);
    chk("hit_resp2", resp_log[r0 + 2], 32'h100C);
    chk("hit_gap01", 32'(resp_cyc_log[r0 + 1] - resp_cyc_log[r0]), 32'd1);
    chk("hit_gap12", 32'(resp_cyc_log[r0 + 2] - resp_cyc_log[r0 + 1]), 32'd1);
    chk("hit_no_fill", 32'(ack_total - a0), 32'd0);

    // Conflict miss on the same index
    n0 = ack_adr_log.size();
    r0 = resp_log.size();
    issue(32'h0000_2004);
    wait_quiet();
    chk("conf_adr0", ack_adr_log[n0], 32'h2000);
    chk("conf_adr3", ack_adr_log[n0 + 3], 32'h200C);
    chk("conf_resp", resp_log[r0], 32'h2004);
    a0 = ack_total;
    issue(32'h0000_1004);
    wait_quiet();
    chk("conf_refill", 32'(ack_total - a0), 32'd4);
    chk("conf_resp2", resp_log[resp_log.size() - 1], 32'h1004);

    // Flush during fill, 2-cycle ack gaps
    ack_gap = 2;
    a0 = ack_total;
    r0 = resp_log.size();
    issue(32'h0000_3018);
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (memAck && ack_total == a0 + 1) begin
        flush = 1'b1;
        @(posedge clk);
        #2;
        flush = 1'b0;
        done = 1'b1;
        break;
      end
    end
    chk("fdf_flush_pulsed", {31'b0, done}, 32'd1);
    wait_quiet();
    chk("fdf_resp_count", 32'(resp_log.size() - r0), 32'd1);
    chk("fdf_resp", resp_log[r0], 32'h3018);
    ack_gap = 0;
    a0 = ack_total;
    issue(32'h0000_3018);
    wait_quiet();
    chk("fdf_remiss", 32'(ack_total - a0), 32'd4);

    // Reset mid-fill
    a0 = ack_total;
    r0 = resp_log.size();
    issue(32'h0000_4020);
    done = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #2;
      if (ack_total == a0 + 2) begin
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        done = 1'b1;
        break;
      end
    end
    chk("rmf_reset_pulsed", {31'b0, done}, 32'd1);
    @(negedge clk);
    chk("rmf_memReq", {31'b0, memReq}, 32'd0);
    chk("rmf_respValid", {31'b0, respValid}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("rmf_no_resp", 32'(resp_log.size() - r0), 32'd0);
    a0 = ack_total;
    issue(32'h0000_4020);
    wait_quiet();
    chk("rmf_full_fill", 32'(ack_total - a0), 32'd4);
    chk("rmf_resp", resp_log[resp_log.size() - 1], 32'h4020);

    // Flush and request together in IDLE
    flush = 1'b1;
    reqValid = 1'b1;
    reqAdr = 32'h0000_4024;
    fc = cyc;
    @(negedge clk);
    chk("sim_ready_low", {31'b0, reqReady}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    done = 1'b0;
    ac = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (reqReady === 1'b1) begin
        ac = cyc;
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    chk("sim_accepted", {31'b0, done}, 32'd1);
    chk("sim_delay", 32'(ac - fc), 32'd2);
    wait_quiet();
    chk("sim_resp", resp_log[resp_log.size() - 1], 32'h4024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    miscompares++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
